// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//
// Pipeline interlock for a classic 5-stage in-order core with branches
// resolved in ID. It detects data hazards seen by the instruction in IF/ID,
// inserts 1 or 2 bubble cycles, and freezes the whole pipe while a data
// memory access is outstanding.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   id_rs, id_rt, id_uses_rt       IF/ID source registers
//   id_branch, branch_taken        IF/ID branch and its ID-stage outcome
//   id_ex_memread, id_ex_regwrite  ID/EX control
//   id_ex_wreg                     ID/EX destination register
//   ex_mem_memread, ex_mem_memwrite, ex_mem_wreg   EX/MEM control/dest
//   dmem_ack                       data memory done (single-cycle pulse)
//   pc_write, if_id_write          front-end load enables
//   id_ex_bubble                   zero ID/EX control (insert nop)
//   pipe_freeze                    hold every pipeline register
//   if_id_flush                    squash IF/ID on a taken branch
//   dmem_req                       data memory request
//   stall_cycles                   saturating count of stall/freeze cycles
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             branch_taken,
  input  logic             id_ex_memread,
  input  logic             id_ex_regwrite,
  input  logic [4:0]       id_ex_wreg,
  input  logic             ex_mem_memread,
  input  logic             ex_mem_memwrite,
  input  logic [4:0]       ex_mem_wreg,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic             if_id_flush,
  output logic             dmem_req,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    MEMWAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  state_e           sv_state_q, sv_state_d;   // state to resume after MEMWAIT
  logic [1:0]       rem_q, rem_d;
  logic [1:0]       sv_rem_q, sv_rem_d;       // rem to resume after MEMWAIT
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  // -------------------------------------------------------------------------
  // Hazard detection (register 0 never creates a dependency)
  // -------------------------------------------------------------------------
  logic       ex_nz, mem_nz;
  logic       rs_ex, rt_ex, rs_mem, rt_mem;
  logic       load_use, br_ex, br_mem;
  logic [1:0] haz_n;
  logic       mem_access;

  always_comb begin
    ex_nz    = (id_ex_wreg  != 5'd0);
    mem_nz   = (ex_mem_wreg != 5'd0);
    rs_ex    = ex_nz  & (id_ex_wreg  == id_rs);
    rt_ex    = ex_nz  & (id_ex_wreg  == id_rt);
    rs_mem   = mem_nz & (ex_mem_wreg == id_rs);
    rt_mem   = mem_nz & (ex_mem_wreg == id_rt);

    load_use = id_ex_memread & (rs_ex | (id_uses_rt & rt_ex));
    // A branch compares in ID, so it needs any producer in EX retired;
    // a load in EX costs one more cycle than an ALU producer.
    br_ex    = id_branch & id_ex_regwrite & (rs_ex | rt_ex);
    br_mem   = id_branch & ex_mem_memread & (rs_mem | rt_mem);

    // Largest applicable stall length wins.
    if (br_ex & id_ex_memread)           haz_n = 2'd2;
    else if (load_use | br_ex | br_mem)  haz_n = 2'd1;
    else                                 haz_n = 2'd0;

    mem_access = ex_mem_memread | ex_mem_memwrite;
  end

  // -------------------------------------------------------------------------
  // Stall / freeze FSM
  // -------------------------------------------------------------------------
  logic stall, freeze, req;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sv_state_d = sv_state_q;
    sv_rem_d   = sv_rem_q;
    stall      = 1'b0;
    freeze     = 1'b0;
    req        = 1'b0;

    unique case (state_q)
      IDLE, STALL: begin
        req = mem_access;
        if (mem_access & ~dmem_ack) begin
          // Freeze wins over any stall: park the stall context and wait.
          freeze     = 1'b1;
          sv_state_d = state_q;
          sv_rem_d   = rem_q;
          state_d    = MEMWAIT;
        end else if (state_q == STALL) begin
          // Stall already committed; hazards are not re-evaluated here.
          stall = 1'b1;
          if (rem_q <= 2'd1) begin
            rem_d   = 2'd0;
            state_d = IDLE;
          end else begin
            rem_d   = rem_q - 2'd1;
          end
        end else if (haz_n != 2'd0) begin
          // First stall cycle is issued combinationally in IDLE.
          stall   = 1'b1;
          rem_d   = haz_n - 2'd1;
          state_d = (haz_n == 2'd2) ? STALL : IDLE;
        end
      end

      MEMWAIT: begin
        req = 1'b1;
        if (dmem_ack) begin
          state_d    = sv_state_q;
          rem_d      = sv_rem_q;
          sv_state_d = IDLE;
          sv_rem_d   = 2'd0;
        end else begin
          freeze = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        rem_d   = 2'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs; reset forces the idle output values even though the FSM
  // outputs are partly combinational on the inputs.
  // -------------------------------------------------------------------------
  logic stall_o, freeze_o;

  always_comb begin
    stall_o      = stall  & rst_n;
    freeze_o     = freeze & rst_n;
    pc_write     = ~(stall_o | freeze_o);
    if_id_write  = ~(stall_o | freeze_o);
    id_ex_bubble = stall_o & ~freeze_o;
    pipe_freeze  = freeze_o;
    if_id_flush  = rst_n & id_branch & branch_taken & ~stall_o & ~freeze_o;
    dmem_req     = req & rst_n;
    stall_cycles = stall_cycles_q;
  end

  // Saturating event counter.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((stall_o | freeze_o) && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rem_q          <= 2'd0;
      sv_state_q     <= IDLE;
      sv_rem_q       <= 2'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      sv_state_q     <= sv_state_d;
      sv_rem_q       <= sv_rem_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Directed bench: a table of single-cycle vectors applied from IDLE, then
// hand-written multi-cycle sequences for stalls, memory waits and reset.
// Output vector order: {pc_write, if_id_write, id_ex_bubble, pipe_freeze,
// if_id_flush, dmem_req}.
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, id_ex_wreg, ex_mem_wreg;
  logic        id_uses_rt, id_branch, branch_taken;
  logic        id_ex_memread, id_ex_regwrite;
  logic        ex_mem_memread, ex_mem_memwrite, dmem_ack;
  logic        pc_write, if_id_write, id_ex_bubble, pipe_freeze, if_id_flush, dmem_req;
  logic [15:0] stall_cycles;
  logic        s_pc_write, s_if_id_write, s_id_ex_bubble, s_pipe_freeze, s_if_id_flush, s_dmem_req;
  logic [3:0]  s_stall_cycles;

  always #5 clk = ~clk;

  hazard_stall_unit #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .branch_taken(branch_taken), .id_ex_memread(id_ex_memread),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_wreg(id_ex_wreg), .ex_mem_memread(ex_mem_memread),
    .ex_mem_memwrite(ex_mem_memwrite), .ex_mem_wreg(ex_mem_wreg), .dmem_ack(dmem_ack),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .pipe_freeze(pipe_freeze), .if_id_flush(if_id_flush), .dmem_req(dmem_req),
    .stall_cycles(stall_cycles)
  );

  hazard_stall_unit #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .branch_taken(branch_taken), .id_ex_memread(id_ex_memread),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_wreg(id_ex_wreg), .ex_mem_memread(ex_mem_memread),
    .ex_mem_memwrite(ex_mem_memwrite), .ex_mem_wreg(ex_mem_wreg), .dmem_ack(dmem_ack),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_ex_bubble(s_id_ex_bubble),
    .pipe_freeze(s_pipe_freeze), .if_id_flush(s_if_id_flush), .dmem_req(s_dmem_req),
    .stall_cycles(s_stall_cycles)
  );

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       ur, br, tk, xmr, xrw;
    logic [4:0] xw;
    logic       mmr, mmw;
    logic [4:0] mw;
    logic       ack;
    logic [5:0] exp;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  int nbub;
  vec_t vt[15];

  function automatic vec_t mk(input string nm, input int rs, input int rt, input int ur,
                              input int br, input int tk, input int xmr, input int xrw,
                              input int xw, input int mmr, input int mmw, input int mw,
                              input int ack, input logic [5:0] exp);
    vec_t v;
    v.name = nm;  v.rs = 5'(rs);  v.rt = 5'(rt);  v.ur = 1'(ur);
    v.br = 1'(br); v.tk = 1'(tk); v.xmr = 1'(xmr); v.xrw = 1'(xrw);
    v.xw = 5'(xw); v.mmr = 1'(mmr); v.mmw = 1'(mmw); v.mw = 5'(mw);
    v.ack = 1'(ack); v.exp = exp;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {pc_write, if_id_write, id_ex_bubble, pipe_freeze, if_id_flush, dmem_req};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic clr_in();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_branch = 0; branch_taken = 0;
    id_ex_memread = 0; id_ex_regwrite = 0; id_ex_wreg = 0;
    ex_mem_memread = 0; ex_mem_memwrite = 0; ex_mem_wreg = 0; dmem_ack = 0;
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.ur; id_branch = v.br; branch_taken = v.tk;
    id_ex_memread = v.xmr; id_ex_regwrite = v.xrw; id_ex_wreg = v.xw;
    ex_mem_memread = v.mmr; ex_mem_memwrite = v.mmw; ex_mem_wreg = v.mw; dmem_ack = v.ack;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_in();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    //            name              rs rt ur br tk xmr xrw xw mmr mmw mw ack  exp
    vt[0]  = mk("idle",            0, 0, 0, 0, 0, 0,  0,  0, 0,  0,  0, 0, 6'b110000);
    vt[1]  = mk("lu_rs",           5, 0, 0, 0, 0, 1,  0,  5, 0,  0,  0, 0, 6'b001000);
    vt[2]  = mk("lu_rt",           3, 7, 1, 0, 0, 1,  0,  7, 0,  0,  0, 0, 6'b001000);
    vt[3]  = mk("lu_rt_unused",    3, 7, 0, 0, 0, 1,  0,  7, 0,  0,  0, 0, 6'b110000);
    vt[4]  = mk("lu_r0",           0, 0, 0, 0, 0, 1,  0,  0, 0,  0,  0, 0, 6'b110000);
    vt[5]  = mk("r0_br_flush",     0, 0, 0, 1, 1, 1,  0,  0, 0,  0,  0, 0, 6'b110010);
    vt[6]  = mk("br_flush",        1, 2, 1, 1, 1, 0,  1,  3, 0,  0,  0, 0, 6'b110010);
    vt[7]  = mk("br_ex_rw",        4, 2, 1, 1, 1, 0,  1,  4, 0,  0,  0, 0, 6'b001000);
    vt[8]  = mk("br_mem_ld",       1, 6, 1, 1, 0, 0,  0,  0, 1,  0,  6, 1, 6'b001001);
    vt[9]  = mk("mem_freeze",      0, 0, 0, 0, 0, 0,  0,  0, 0,  1,  0, 0, 6'b000101);
    vt[10] = mk("mem_ack",         0, 0, 0, 0, 0, 0,  0,  0, 0,  1,  0, 1, 6'b110001);
    vt[11] = mk("ack_only",        0, 0, 0, 0, 0, 0,  0,  0, 0,  0,  0, 1, 6'b110000);
    vt[12] = mk("frz_over_lu",     5, 0, 0, 0, 0, 1,  0,  5, 1,  0,  9, 0, 6'b000101);
    vt[13] = mk("frz_over_flush",  1, 2, 0, 1, 1, 0,  0,  0, 0,  1,  0, 0, 6'b000101);
    vt[14] = mk("br_rw_r0",        0, 0, 1, 1, 0, 0,  1,  0, 0,  0,  0, 0, 6'b110000);

    // Reset values, with inputs that would otherwise request memory.
    rst_n = 1'b0;
    clr_in();
    ex_mem_memwrite = 1; id_branch = 1; branch_taken = 1;
    #2;
    chk("reset_outs", outs(), 6'b110000);
    chk("reset_cnt", stall_cycles, 0);
    do_reset();

    // Single-cycle vectors, each from a freshly reset IDLE.
    for (int i = 0; i < 15; i++) begin
      apply(vt[i]);
      #1;
      chk(vt[i].name, outs(), vt[i].exp);
      do_reset();
    end

    // Load-use: exactly one stall cycle.
    id_ex_memread = 1; id_ex_wreg = 5; id_rs = 5;
    #1 chk("lu_c1", outs(), 6'b001000);
    tick(); clr_in();
    #1 chk("lu_c2", outs(), 6'b110000);
    chk("lu_cnt", stall_cycles, 1);

    // Branch on a load result: two stalls, no flush, second stall ignores inputs.
    do_reset();
    id_branch = 1; branch_taken = 1; id_ex_memread = 1; id_ex_regwrite = 1;
    id_ex_wreg = 8; id_rt = 8; id_uses_rt = 1;
    #1 chk("br2_c1", outs(), 6'b001000);
    tick(); clr_in(); id_branch = 1; branch_taken = 1;
    #1 chk("br2_c2", outs(), 6'b001000);
    tick(); clr_in();
    #1 chk("br2_c3", outs(), 6'b110000);
    chk("br2_cnt", stall_cycles, 2);

    // Store with ack on the 4th cycle: three freeze cycles.
    do_reset();
    ex_mem_memwrite = 1;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("mw_frz%0d", c), outs(), 6'b000101);
      tick();
    end
    dmem_ack = 1;
    #1 chk("mw_ack", outs(), 6'b110001);
    tick(); clr_in();
    #1 chk("mw_after", outs(), 6'b110000);
    chk("mw_cnt", stall_cycles, 3);

    // Memory access arriving mid 2-cycle stall with rem=1.
    do_reset();
    nbub = 0;
    id_branch = 1; id_ex_memread = 1; id_ex_regwrite = 1; id_ex_wreg = 8; id_rt = 8; id_uses_rt = 1;
    #1 chk("ms_c1", outs(), 6'b001000); nbub += int'(id_ex_bubble);
    tick(); clr_in(); ex_mem_memread = 1; ex_mem_wreg = 3;
    #1 chk("ms_frz1", outs(), 6'b000101); nbub += int'(id_ex_bubble);
    tick();
    #1 chk("ms_frz2", outs(), 6'b000101); nbub += int'(id_ex_bubble);
    tick(); dmem_ack = 1;
    #1 chk("ms_ack", outs(), 6'b110001); nbub += int'(id_ex_bubble);
    tick(); clr_in();
    #1 chk("ms_resume", outs(), 6'b001000); nbub += int'(id_ex_bubble);
    tick();
    #1 chk("ms_done", outs(), 6'b110000); nbub += int'(id_ex_bubble);
    chk("ms_bubbles", nbub, 2);
    chk("ms_cnt", stall_cycles, 4);

    // Reset during MEMWAIT abandons the access.
    do_reset();
    ex_mem_memwrite = 1;
    tick();
    #1 chk("rw_memwait", outs(), 6'b000101);
    rst_n = 1'b0;
    #1 chk("rw_in_reset", outs(), 6'b110000);
    chk("rw_cnt_reset", stall_cycles, 0);
    tick(); rst_n = 1'b1; clr_in();
    #1 chk("rw_release", outs(), 6'b110000);
    chk("rw_cnt_release", stall_cycles, 0);
    dmem_ack = 1;
    #1 chk("rw_stray_ack", outs(), 6'b110000);
    tick(); clr_in(); id_ex_memread = 1; id_ex_wreg = 5; id_rs = 5;
    #1 chk("rw_idle_hazard", outs(), 6'b001000);

    // Saturation: 20 consecutive stall cycles.
    do_reset();
    id_ex_memread = 1; id_ex_wreg = 5; id_rs = 5;
    repeat (20) tick();
    clr_in();
    #1 chk("sat_cnt4", s_stall_cycles, 15);
    chk("sat_cnt16", stall_cycles, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
